// File: rtl/mine_placer.sv
// Mine placement engine for a 5x5 Minesweeper board: draws cells from a free-running
// 5-bit LFSR, rejects out-of-range and duplicate cells, and answers single-cell probes.
module mine_placer #(
  parameter int unsigned CELLS = 25,
  parameter int unsigned MINES = 5,
  parameter logic [4:0]  SEED  = 5'h01
) (
  input  logic        clka,
  input  logic        restart,
  input  logic        start,
  input  logic [4:0]  probe_addr,
  output logic        place_done,
  output logic [24:0] mine_map,
  output logic [4:0]  mine_count,
  output logic        probe_mine
);

  localparam logic [4:0] SEED_EFF = (SEED == 5'd0) ? 5'h01 : SEED;

  typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  lfsr, lfsr_next;
  logic [4:0]  cand;
  logic [31:0] map_ext;
  logic        accept, last, clear_board, probe_hit;

  always_comb begin
    lfsr_next = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
    cand      = lfsr - 5'd1;
    map_ext   = {7'd0, mine_map};
    accept    = (state == PLACE) && (32'(cand) < CELLS) && !map_ext[cand];
    last      = accept && ((32'(mine_count) + 32'd1) == MINES);
    probe_hit = (32'(probe_addr) < CELLS) && map_ext[probe_addr];
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = PLACE;
      PLACE:   if (last) state_next = DONE;
      DONE:    if (start) state_next = CLEAR;
      default: state_next = IDLE;
    endcase
  end

  // Board is wiped on the edge that enters CLEAR so place_done drops one cycle after start.
  assign clear_board = (state_next == CLEAR) || (state == CLEAR);

  always_ff @(negedge clka) begin
    if (restart) begin
      state      <= IDLE;
      lfsr       <= SEED_EFF;
      mine_map   <= '0;
      mine_count <= '0;
      place_done <= 1'b0;
      probe_mine <= 1'b0;
    end else begin
      state      <= state_next;
      lfsr       <= lfsr_next;
      probe_mine <= probe_hit;
      if (clear_board) begin
        mine_map   <= '0;
        mine_count <= '0;
        place_done <= 1'b0;
      end else if (accept) begin
        mine_map   <= mine_map | (25'd1 << cand);
        mine_count <= mine_count + 5'd1;
        if (last) place_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer: three instances (MINES=3, MINES=12, SEED=0) share stimulus.
module tb_mine_placer;

  logic        clka = 1'b1;
  logic        restart, start;
  logic [4:0]  probe_addr;
  logic        done_a, done_b, done_c;
  logic [24:0] map_a, map_b, map_c;
  logic [4:0]  cnt_a, cnt_b, cnt_c;
  logic        pm_a, pm_b, pm_c;

  int checks = 0;
  int errors = 0;
  int da, db, dc;
  logic [24:0] map_a_k3;
  logic [4:0]  cnt_a_k3, cnt_b_k16;

  always #5 clka = ~clka;

  mine_placer #(.CELLS(25), .MINES(3), .SEED(5'h01)) dut_a (
    .clka(clka), .restart(restart), .start(start), .probe_addr(probe_addr),
    .place_done(done_a), .mine_map(map_a), .mine_count(cnt_a), .probe_mine(pm_a));
  mine_placer #(.CELLS(25), .MINES(12), .SEED(5'h01)) dut_b (
    .clka(clka), .restart(restart), .start(start), .probe_addr(probe_addr),
    .place_done(done_b), .mine_map(map_b), .mine_count(cnt_b), .probe_mine(pm_b));
  mine_placer #(.CELLS(25), .MINES(3), .SEED(5'h00)) dut_c (
    .clka(clka), .restart(restart), .start(start), .probe_addr(probe_addr),
    .place_done(done_c), .mine_map(map_c), .mine_count(cnt_c), .probe_mine(pm_c));

  typedef struct {
    logic [4:0] addr;
    logic       exp;
  } probe_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  // Outputs sampled on posedge; DUT updates on negedge.
  task automatic do_reset();
    @(posedge clka);
    restart = 1'b1; start = 1'b0;
    repeat (2) @(posedge clka);
    restart = 1'b0;
  endtask

  // Caller has just raised start after a posedge (cycle n); k counts following cycles.
  task automatic run_pass(input int pulse_at, input int limit);
    da = 0; db = 0; dc = 0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clka);
      start = (k == pulse_at);
      if (k == 3) begin map_a_k3 = map_a; cnt_a_k3 = cnt_a; end
      if (k == 16) cnt_b_k16 = cnt_b;
      if (done_a && da == 0) da = k;
      if (done_b && db == 0) db = k;
      if (done_c && dc == 0) dc = k;
    end
    start = 1'b0;
  endtask

  probe_vec_t pv [8];

  initial begin
    pv[0] = '{5'd8,  1'b1};
    pv[1] = '{5'd9,  1'b0};
    pv[2] = '{5'd27, 1'b0};
    pv[3] = '{5'd3,  1'b1};
    pv[4] = '{5'd17, 1'b1};
    pv[5] = '{5'd0,  1'b0};
    pv[6] = '{5'd24, 1'b0};
    pv[7] = '{5'd31, 1'b0};

    restart = 1'b1; start = 1'b0; probe_addr = 5'd0;
    repeat (2) @(posedge clka);
    check("rst_done", 32'(done_a), 0);
    check("rst_map", 32'(map_a), 0);
    check("rst_cnt", 32'(cnt_a), 0);
    check("rst_probe", 32'(pm_a), 0);
    check("rst_lfsr", 32'(dut_a.lfsr), 1);
    check("rst_lfsr_seed0", 32'(dut_c.lfsr), 1);

    // Basic placement and rejection path, start on first cycle after reset
    restart = 1'b0; start = 1'b1;
    run_pass(0, 30);
    check("basic_k3_map", 32'(map_a_k3), 32'h8);
    check("basic_k3_cnt", 32'(cnt_a_k3), 1);
    check("basic_done_cycle", da, 5);
    check("basic_map", 32'(map_a), 32'h0020108);
    check("basic_cnt", 32'(cnt_a), 3);
    check("seed0_map", 32'(map_c), 32'h0020108);
    check("seed0_done_cycle", dc, 5);
    check("rej_cnt_k16", 32'(cnt_b_k16), 11);
    check("rej_done_cycle", db, 17);
    check("rej_map", 32'(map_b), 32'h1A64D58);
    check("rej_cnt", 32'(cnt_b), 12);

    foreach (pv[i]) begin
      probe_addr = pv[i].addr;
      @(posedge clka);
      check($sformatf("probe_%0d", pv[i].addr), 32'(pm_a), 32'(pv[i].exp));
    end

    // Regeneration from DONE
    start = 1'b1;
    @(posedge clka);
    start = 1'b0;
    check("regen_done_low", 32'(done_a), 0);
    check("regen_map_zero", 32'(map_a), 0);
    check("regen_b_map_zero", 32'(map_b), 0);
    run_pass(0, 45);
    check("regen_done", 32'(done_a), 1);
    check("regen_cnt", 32'(cnt_a), 3);
    check("regen_pop", $countones(map_a), 3);
    check("regen_b_done", 32'(done_b), 1);
    check("regen_b_cnt", 32'(cnt_b), 12);
    check("regen_b_pop", $countones(map_b), 12);

    // start pulsed during PLACE is ignored
    do_reset();
    start = 1'b1;
    run_pass(3, 30);
    check("ign_done_cycle", da, 5);
    check("ign_map", 32'(map_a), 32'h0020108);
    check("ign_rej_map", 32'(map_b), 32'h1A64D58);

    // restart during second PLACE cycle
    do_reset();
    start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clka);
      start = 1'b0;
    end
    check("mid_map_before", 32'(map_a), 32'h8);
    restart = 1'b1;
    @(posedge clka);
    restart = 1'b0;
    check("mid_map", 32'(map_a), 0);
    check("mid_cnt", 32'(cnt_a), 0);
    check("mid_done", 32'(done_a), 0);
    check("mid_lfsr", 32'(dut_a.lfsr), 1);
    repeat (10) @(posedge clka);
    check("mid_idle_done", 32'(done_a), 0);
    check("mid_idle_map", 32'(map_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
